// File: rtl/vec_xfer_buff.sv
// Byte-serial vector transfer engine: independent load (host -> vector) and
// store (vector -> host) channels over a BUS-wide valid/ready host bus.
module vec_xfer_buff #(
  parameter int BITS = 8,
  parameter int N    = 64,
  parameter int BUS  = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [BUS-1:0]    in_bus,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N*BITS-1:0] ld_vec,
  output logic [7:0]        ld_len,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              st_req,
  input  logic [N*BITS-1:0] st_vec,
  input  logic [7:0]        st_len,
  output logic              st_busy,
  output logic [BUS-1:0]    out_bus,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              abort
);

  localparam int BEATS = BITS / BUS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORDS = N * BEATS;
  localparam int SW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [7:0]    N8        = 8'(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // ---------------- load channel ----------------
  typedef enum logic {L_LEN, L_DATA} ld_state_t;
  ld_state_t ld_state_reg, ld_state_next;

  logic [7:0]    ld_elem_reg;
  logic [BW-1:0] ld_beat_reg;
  logic [7:0]    ld_len_reg;
  logic          ld_err_reg;
  logic          ld_done_reg;
  logic          rdy_reg;
  logic [7:0]    raw_len, clamp_len;
  logic          in_hs, len_hs, data_hs, beat_last, elem_last;

  // in_ready drops for the single bubble cycle that carries ld_done
  assign in_ready  = rdy_reg & ~ld_done_reg;
  assign in_hs     = in_valid & in_ready;
  assign len_hs    = in_hs & ~abort & (ld_state_reg == L_LEN);
  assign data_hs   = in_hs & ~abort & (ld_state_reg == L_DATA);
  assign raw_len   = in_bus[7:0];
  assign clamp_len = (raw_len > N8) ? N8 : raw_len;
  assign beat_last = (ld_beat_reg == LAST_BEAT);
  assign elem_last = (ld_elem_reg == ld_len_reg - 8'd1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) ld_state_reg <= L_LEN;
    else        ld_state_reg <= ld_state_next;
  end

  always_comb begin
    ld_state_next = ld_state_reg;
    if (abort) begin
      ld_state_next = L_LEN;
    end else begin
      case (ld_state_reg)
        L_LEN:   if (len_hs && clamp_len != 8'd0) ld_state_next = L_DATA;
        L_DATA:  if (data_hs && beat_last && elem_last) ld_state_next = L_LEN;
        default: ld_state_next = L_LEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdy_reg     <= 1'b0;
      ld_done_reg <= 1'b0;
      ld_len_reg  <= 8'd0;
      ld_err_reg  <= 1'b0;
      ld_elem_reg <= 8'd0;
      ld_beat_reg <= '0;
    end else begin
      rdy_reg     <= 1'b1;
      ld_done_reg <= 1'b0;
      if (abort) begin
        ld_elem_reg <= 8'd0;
        ld_beat_reg <= '0;
      end else if (len_hs) begin
        ld_len_reg  <= clamp_len;
        ld_err_reg  <= (raw_len > N8);
        ld_elem_reg <= 8'd0;
        ld_beat_reg <= '0;
        ld_done_reg <= (clamp_len == 8'd0);
      end else if (data_hs) begin
        if (beat_last) begin
          ld_beat_reg <= '0;
          if (elem_last) begin
            ld_elem_reg <= 8'd0;
            ld_done_reg <= 1'b1;
          end else begin
            ld_elem_reg <= ld_elem_reg + 8'd1;
          end
        end else begin
          ld_beat_reg <= ld_beat_reg + BW'(1);
        end
      end
    end
  end

  // Each element owns its register; beats land little-endian within it
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    logic [BITS-1:0] elem_reg;
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        elem_reg <= '0;
      end else if (len_hs) begin
        elem_reg <= '0;
      end else if (data_hs && ld_elem_reg == 8'(gi)) begin
        for (int b = 0; b < BEATS; b++)
          if (int'(ld_beat_reg) == b) elem_reg[b*BUS +: BUS] <= in_bus;
      end
    end
    assign ld_vec[gi*BITS +: BITS] = elem_reg;
  end

  assign ld_len  = ld_len_reg;
  assign ld_done = ld_done_reg;
  assign ld_err  = ld_err_reg;

  // ---------------- store channel ----------------
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA} st_state_t;
  st_state_t st_state_reg, st_state_next;

  logic [N*BITS-1:0] snap_reg;
  logic [7:0]        st_len_reg;
  logic [SW-1:0]     s_word_reg, s_last_reg;
  logic [BUS-1:0]    out_bus_reg;
  logic              out_valid_reg, st_busy_reg;
  logic [7:0]        st_clamp;
  logic [BUS-1:0]    snap_word [WORDS];

  assign st_clamp = (st_len > N8) ? N8 : st_len;

  // Flat word view of the snapshot: word index = elem*BEATS + beat
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign snap_word[gi] = snap_reg[gi*BUS +: BUS];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) st_state_reg <= S_IDLE;
    else        st_state_reg <= st_state_next;
  end

  always_comb begin
    st_state_next = st_state_reg;
    if (abort) begin
      st_state_next = S_IDLE;
    end else begin
      case (st_state_reg)
        S_IDLE:  if (st_req) st_state_next = S_LEN;
        S_LEN:   if (out_ready) st_state_next = (st_len_reg == 8'd0) ? S_IDLE : S_DATA;
        S_DATA:  if (out_ready && s_word_reg == s_last_reg) st_state_next = S_IDLE;
        default: st_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      snap_reg      <= '0;
      st_len_reg    <= 8'd0;
      s_word_reg    <= '0;
      s_last_reg    <= '0;
      out_bus_reg   <= '0;
      out_valid_reg <= 1'b0;
      st_busy_reg   <= 1'b0;
    end else if (abort) begin
      s_word_reg    <= '0;
      out_valid_reg <= 1'b0;
      st_busy_reg   <= 1'b0;
    end else begin
      case (st_state_reg)
        S_IDLE: if (st_req) begin
          snap_reg      <= st_vec;
          st_len_reg    <= st_clamp;
          s_last_reg    <= SW'(int'(st_clamp) * BEATS - 1);
          s_word_reg    <= '0;
          out_bus_reg   <= BUS'(st_clamp);
          out_valid_reg <= 1'b1;
          st_busy_reg   <= 1'b1;
        end
        S_LEN: if (out_ready) begin
          if (st_len_reg == 8'd0) begin
            out_valid_reg <= 1'b0;
            st_busy_reg   <= 1'b0;
          end else begin
            s_word_reg  <= '0;
            out_bus_reg <= snap_word[0];
          end
        end
        S_DATA: if (out_ready) begin
          if (s_word_reg == s_last_reg) begin
            out_valid_reg <= 1'b0;
            st_busy_reg   <= 1'b0;
          end else begin
            s_word_reg  <= s_word_reg + SW'(1);
            out_bus_reg <= snap_word[s_word_reg + SW'(1)];
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          st_busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign out_bus   = out_bus_reg;
  assign out_valid = out_valid_reg;
  assign st_busy   = st_busy_reg;

endmodule

// File: tb/tb_vec_xfer_buff.sv
// Directed self-checking bench for vec_xfer_buff with BITS=16, BUS=8, N=4.
module tb_vec_xfer_buff;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [7:0]  in_bus;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ld_vec;
  logic [7:0]  ld_len;
  logic        ld_done;
  logic        ld_err;
  logic        st_req;
  logic [63:0] st_vec;
  logic [7:0]  st_len;
  logic        st_busy;
  logic [7:0]  out_bus;
  logic        out_valid;
  logic        out_ready;
  logic        abort;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_seq [16];

  vec_xfer_buff #(.BITS(16), .N(4), .BUS(8)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .ld_vec(ld_vec), .ld_len(ld_len), .ld_done(ld_done), .ld_err(ld_err),
    .st_req(st_req), .st_vec(st_vec), .st_len(st_len), .st_busy(st_busy),
    .out_bus(out_bus), .out_valid(out_valid), .out_ready(out_ready),
    .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_bus   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Consume n store beats, optionally stalling every other cycle
  task automatic drain(input int n, input bit toggle);
    int idx = 0;
    for (int c = 0; c < 64 && idx < n; c++) begin
      out_ready = toggle ? ((c % 2) == 0) : 1'b1;
      chk("st_valid", out_valid, 1);
      chk("st_busy", st_busy, 1);
      chk("st_bus", out_bus, exp_seq[idx]);
      if (out_ready) idx++;
      tick();
    end
    out_ready = 1'b0;
    chk("st_count", idx, n);
    chk("st_valid_end", out_valid, 0);
    chk("st_busy_end", st_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_l = 1'b0; in_bus = 8'h00; in_valid = 1'b0; st_req = 1'b0;
    st_vec = 64'h0; st_len = 8'h0; out_ready = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ld_vec", ld_vec, 0);
    chk("rst_ld_len", ld_len, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_st_busy", st_busy, 0);
    chk("rst_out_bus", out_bus, 0);
    rst_l = 1'b1;
    chk("rel_in_ready0", in_ready, 0);
    tick();
    chk("rel_in_ready1", in_ready, 1);

    // load 02 34 12 78 56
    send(8'h02);
    chk("l1_len", ld_len, 8'd2);
    send(8'h34); send(8'h12); send(8'h78);
    chk("l1_nodone", ld_done, 0);
    send(8'h56);
    chk("l1_done", ld_done, 1);
    chk("l1_bubble", in_ready, 0);
    chk("l1_vec", ld_vec, 64'h0000_0000_5678_1234);
    chk("l1_err", ld_err, 0);
    tick();
    chk("l1_done_pulse", ld_done, 0);
    chk("l1_ready_back", in_ready, 1);

    // over-length request, clamped to N
    send(8'h07);
    chk("l2_len", ld_len, 8'd4);
    chk("l2_err", ld_err, 1);
    chk("l2_cleared", ld_vec, 0);
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("l2_done", ld_done, 1);
    chk("l2_vec", ld_vec, 64'h0807_0605_0403_0201);
    chk("l2_err_held", ld_err, 1);
    tick();
    // zero-length load
    send(8'h00);
    chk("l3_done", ld_done, 1);
    chk("l3_err", ld_err, 0);
    chk("l3_len", ld_len, 0);
    chk("l3_vec", ld_vec, 0);
    chk("l3_bubble", in_ready, 0);
    tick();
    chk("l3_done_pulse", ld_done, 0);

    // store of length 3 with out_ready toggling
    st_vec = 64'h0000_EEFF_CCDD_AABB; st_len = 8'd3; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    exp_seq[0] = 8'h03; exp_seq[1] = 8'hBB; exp_seq[2] = 8'hAA; exp_seq[3] = 8'hDD;
    exp_seq[4] = 8'hCC; exp_seq[5] = 8'hFF; exp_seq[6] = 8'hEE;
    drain(7, 1'b1);

    // st_req while busy is ignored, original snapshot is streamed
    st_vec = 64'h0000_0000_B2B1_A2A1; st_len = 8'd2; st_req = 1'b1;
    tick();
    st_vec = 64'hFFFF_FFFF_FFFF_FFFF; st_len = 8'd4;
    tick();
    st_req = 1'b0;
    st_vec = 64'h1234_1234_1234_1234;
    exp_seq[0] = 8'h02; exp_seq[1] = 8'hA1; exp_seq[2] = 8'hA2;
    exp_seq[3] = 8'hB1; exp_seq[4] = 8'hB2;
    drain(5, 1'b0);

    // abort during a load and a store in S_DATA
    st_vec = 64'h0000_0000_0BB0_0AA0; st_len = 8'd2; st_req = 1'b1;
    tick();
    st_req = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ab_st_data", out_bus, 8'hA0);
    send(8'h04); send(8'h11); send(8'h22); send(8'h33);
    abort = 1'b1; in_valid = 1'b1; in_bus = 8'h44;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_out_valid", out_valid, 0);
    chk("ab_st_busy", st_busy, 0);
    chk("ab_no_done", ld_done, 0);
    chk("ab_len_kept", ld_len, 8'd4);
    chk("ab_vec_kept", ld_vec, 64'h0000_0000_0033_2211);
    chk("ab_in_ready", in_ready, 1);
    tick();
    chk("ab_no_done2", ld_done, 0);
    send(8'h01);
    chk("ab_l_clear", ld_vec, 0);
    send(8'h11); send(8'h22);
    chk("ab_l_done", ld_done, 1);
    chk("ab_l_vec", ld_vec, 64'h0000_0000_0000_2211);
    chk("ab_l_len", ld_len, 8'd1);
    tick();

    // asynchronous reset mid-store
    st_vec = 64'h0000_0000_0303_0202; st_len = 8'd3; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    chk("ar_busy_pre", st_busy, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_st_busy", st_busy, 0);
    chk("ar_ld_vec", ld_vec, 0);
    chk("ar_in_ready", in_ready, 0);
    rst_l = 1'b1;
    tick();
    chk("ar_ready_first", in_ready, 1);
    send(8'h01); send(8'hAB); send(8'hCD);
    chk("ar_l_done", ld_done, 1);
    chk("ar_l_vec", ld_vec, 64'h0000_0000_0000_CDAB);
    chk("ar_l_len", ld_len, 8'd1);
    chk("ar_no_store", out_valid, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_xfer_buff.md
# vec_xfer_buff

Parametrised byte-serial transfer engine for the vector accelerator data path. It replaces the fixed 8-bit vector immediate buffer and vector output buffer with one block. Elements are `BITS` wide and travel over a `BUS`-wide host bus using valid/ready handshakes. It has an independent load channel (host → vector) and store channel (vector → host), and the two run concurrently.

## Interface
- `BITS`, 8: element width; a multiple of `BUS`.
- `N`, 64: maximum vector length; must not exceed 255.
- `BUS`, 8: host bus width; at least 8. Derived value: `BEATS = BITS/BUS`.

- `clk`  in  1  single clock.
- `rst_l`  in  1  asynchronous, active-low reset.
- `in_bus`  in  BUS  load data.
- `in_valid`  in  1  load beat offered.
- `in_ready`  out  1  load beat accepted when high together with `in_valid`.
- `ld_vec`  out  N*BITS  loaded vector; element i at `[i*BITS +: BITS]`.
- `ld_len`  out  8  loaded length, range 0..N.
- `ld_done`  out  1  one-cycle pulse: load complete.
- `ld_err`  out  1  requested length exceeded N.
- `st_req`  in  1  start a store; sampled only when idle.
- `st_vec`  in  N*BITS  vector to store.
- `st_len`  in  8  store length.
- `st_busy`  out  1  store channel active.
- `out_bus`  out  BUS  store data.
- `out_valid`  out  1  store beat offered.
- `out_ready`  in  1  host accepts the store beat.
- `abort`  in  1  synchronous cancel of both channels.

## Operation
- **Reset** (async, while `rst_l` is low):
  - `ld_vec`, `ld_len`, `ld_done`, `ld_err`, `st_busy`, `out_valid`, `out_bus` are 0.
  - `in_ready` is 0 during reset and 1 from the first clock after deassertion.
  - Both FSMs and all counters are idle/zero.
- **Load FSM** states: `L_LEN`, `L_DATA`.
  - `L_LEN`, on handshake:
    - raw = `in_bus[7:0]`; `ld_len` = min(raw, N); `ld_err` = (raw > N).
    - All `ld_vec` elements cleared to 0.
    - Element counter and beat counter reset to 0.
    - If the clamped length is 0: pulse `ld_done`, stay in `L_LEN`. Otherwise go to `L_DATA`.
  - `L_DATA`, on each handshake:
    - `in_bus` is written to element[elem], bits `[beat*BUS +: BUS]`. Beats are little-endian within an element.
    - beat increments and wraps at `BEATS`, then elem increments.
    - After the handshake on the final beat of element `ld_len-1`: pulse `ld_done`, return to `L_LEN`.
  - `ld_err` is held until the next length beat is accepted.
  - Over-length data beyond N is not consumed. The host sends exactly `ld_len*BEATS` data beats.
- **Store FSM** states: `S_IDLE`, `S_LEN`, `S_DATA`.
  - `S_IDLE`, when `st_req` is high: snapshot `st_vec`, snapshot min(`st_len`, N), go to `S_LEN`.
  - `S_LEN`: `out_valid`=1, `out_bus` = clamped length zero-extended. On `out_ready`: go to `S_DATA`, or to `S_IDLE` if the length is 0.
  - `S_DATA`: `out_bus` = snapshot element[elem] bits `[beat*BUS +: BUS]`, same ordering as load. On the handshake of the last beat go to `S_IDLE`.
  - `st_busy` is high in `S_LEN` and `S_DATA`.
  - `st_req` is ignored while busy.
  - Changes on `st_vec`/`st_len` after the snapshot have no effect.
- **abort**: at the clock edge where it is sampled high:
  - load FSM goes to `L_LEN` and store FSM to `S_IDLE`; counters reset.
  - No `ld_done` pulse is issued.
  - `ld_vec`, `ld_len`, `ld_err` keep their values.
  - `out_valid` and `st_busy` are 0 from the next cycle.
  - `abort` wins over a simultaneous `st_req`, length beat or data beat; that beat is discarded.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- `in_ready` is 0 in the cycle `ld_done` is high: one bubble after each completed load, including a zero-length load. It is 1 otherwise.
- `ld_done` rises in the cycle after the final load handshake. `ld_vec` and `ld_len` are final in that same cycle.
- Load throughput: 1 beat per cycle, so a full load takes 1 + `len*BEATS` handshakes + 1 bubble.
- Store latency: `st_req` sampled at edge t gives `out_valid`=1 from t+1.
  - Length beat first, then 1 beat per cycle while `out_ready` is held high.
  - `out_bus` and `out_valid` hold stable while `out_valid && !out_ready`.
- A new `st_req` is accepted at the earliest in the cycle after the last store handshake, when `st_busy` is 0.
- Load and store share no state. Simultaneous activity on both channels causes no stalls.

## Test plan
- BITS=16, BUS=8, N=4. Load beats `02 34 12 78 56` → `ld_vec` elem0=0x1234, elem1=0x5678, elem2=elem3=0; `ld_len`=2; `ld_done` one cycle after beat 5; `in_ready`=0 in that cycle.
- Same configuration. Length beat 0x07 → `ld_len`=4, `ld_err`=1, 8 data beats complete the load. Next load with length 0x00 → `ld_err` cleared, immediate `ld_done`, `ld_vec` all 0.
- Store `st_len`=3, elements 0xAABB/0xCCDD/0xEEFF, with `out_ready` toggled 1,0,1,0… → `out_bus` sequence `03 BB AA DD CC FF EE` with no duplicated or dropped beats; `out_bus` stable during stalls; `st_busy` drops after `EE`.
- Assert `abort` after the 3rd data beat of a load of length 4 while a store is in `S_DATA` → no `ld_done`; `out_valid`=0 next cycle. A fresh load of length 1, `01 11 22`, then yields elem0=0x2211, `ld_len`=1.
- Drop `rst_l` mid-store, asynchronously between edges → `out_valid`, `st_busy`, `ld_vec` go to 0 immediately. After release, `in_ready`=1 on the first edge and a normal load succeeds.
- `st_req` pulsed while `st_busy`=1, with different `st_vec` → the output stream matches the original snapshot only.
